// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main control FSM and the CPU datapath.
// Latency: none, wires only.
// Backpressure: memory wait-states arrive on mem_ready; every other signal is unflowcontrolled.
// Ports:
//   master - controller side: takes opcode/mem_ready/zero, drives ALU selects and datapath strobes.
//   slave  - datapath side: the mirror image.
// Optional macro CTRL_PERF_CNT_EN adds the retired[15:0] instruction counter.
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_load;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       fault;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired;
`endif

    modport master (
        input  opcode, mem_ready, zero,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond,
               ir_load, i_or_d, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, halted, fault
`ifdef CTRL_PERF_CNT_EN
        , output retired
`endif
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond,
               ir_load, i_or_d, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, halted, fault
`ifdef CTRL_PERF_CNT_EN
        , input retired
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM of the 16-bit CPU: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3-5 cycles per instruction (BEQ/J 3, SW/R/SHIFT/ADDI 4, LW 5) plus memory wait-states.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR while mem_ready=0; MEM_TIMEOUT stalled cycles -> FAULT.
// Ports: clk, rst (async, active-high), ctrl (multicycle_control_if.master).
// Optional macro CTRL_PERF_CNT_EN adds the retired[15:0] counter of completed instructions.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,  // 1..255
    parameter int TO_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        ctrl
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_EXEC_R,
        S_EXEC_S, S_EXEC_I, S_WB_ALU, S_BRANCH, S_JUMP, S_HALT, S_FAULT
    } state_t;

    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_RTYPE = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic            mem_state;
    logic            timeout;
    logic            wb_rtype;   // WB_ALU is shared, so remember whether an R-type fed it

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Counter already holds MEM_TIMEOUT stalled cycles and memory is still not ready.
    assign timeout   = mem_state && !ctrl.mem_ready && (wait_cnt == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (timeout) state_nxt = S_FAULT;
                      else if (ctrl.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (ctrl.opcode)
                    OP_LW, OP_SW: state_nxt = S_ADDR;
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_SHIFT:     state_nxt = S_EXEC_S;
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_HALT:      state_nxt = S_HALT;
                    default:      state_nxt = S_FAULT;
                endcase
            end
            S_ADDR:   state_nxt = (ctrl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (timeout) state_nxt = S_FAULT;
                      else if (ctrl.mem_ready) state_nxt = S_WB_MEM;
            S_MEM_WR: if (timeout) state_nxt = S_FAULT;
                      else if (ctrl.mem_ready) state_nxt = S_FETCH;
            S_EXEC_R, S_EXEC_S, S_EXEC_I: state_nxt = S_WB_ALU;
            S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_FAULT;
        endcase
    end

    // Outputs are decoded from state; reset forces them low asynchronously so a
    // memory access in flight is dropped the moment rst rises.
    always_comb begin
        ctrl.alu_op        = 2'b00;
        ctrl.alu_src_a     = 1'b0;
        ctrl.alu_src_b     = 2'b00;
        ctrl.pc_src        = 2'b00;
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.ir_load       = 1'b0;
        ctrl.i_or_d        = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.reg_dst       = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.halted        = 1'b0;
        ctrl.fault         = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = !timeout;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.ir_load   = ctrl.mem_ready;
                    ctrl.pc_write  = ctrl.mem_ready;
                end
                S_DECODE: ctrl.alu_src_b = 2'b11;
                S_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    ctrl.mem_read = !timeout;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_write = !timeout;
                    ctrl.i_or_d    = 1'b1;
                end
                S_WB_MEM: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_EXEC_R: begin
                    ctrl.alu_op    = 2'b10;
                    ctrl.alu_src_a = 1'b1;
                end
                S_EXEC_S, S_EXEC_I: begin
                    ctrl.alu_op    = 2'b11;
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                end
                S_WB_ALU: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = wb_rtype;
                end
                S_BRANCH: begin
                    ctrl.alu_op        = 2'b01;
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.pc_write_cond = 1'b1;  // datapath qualifies with zero
                    ctrl.pc_src        = 2'b01;
                end
                S_JUMP: begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = 2'b10;
                end
                S_HALT:  ctrl.halted = 1'b1;
                S_FAULT: ctrl.fault  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         wb_rtype <= 1'b0;
        else if (state == S_EXEC_R)      wb_rtype <= 1'b1;
        else if (state == S_EXEC_S || state == S_EXEC_I) wb_rtype <= 1'b0;
    end

    // Counts consecutive stalled cycles of one access; any state change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (mem_state && !ctrl.mem_ready && (state_nxt == state))
            wait_cnt <= wait_cnt + TO_W'(1);
        else
            wait_cnt <= '0;
    end

`ifdef CTRL_PERF_CNT_EN
    // Only completing states (WB_*, MEM_WR, BRANCH, JUMP) can enter FETCH outside reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ctrl.retired <= 16'h0000;
        else if (state != S_FETCH && state_nxt == S_FETCH)
            ctrl.retired <= ctrl.retired + 16'h0001;
    end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control #(.MEM_TIMEOUT(15), .TO_W(8)) dut (.clk(clk), .rst(rst), .ctrl(bus));

    localparam int T_FETCH = 0, T_DECODE = 1, T_ADDR = 2, T_MEM_RD = 3, T_MEM_WR = 4,
                   T_WB_MEM = 5, T_EXEC_R = 6, T_EXEC_S = 7, T_EXEC_I = 8, T_WB_ALU = 9,
                   T_BRANCH = 10, T_JUMP = 11, T_HALT = 12, T_FAULT = 13;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic pc_write, pc_write_cond, ir_load, i_or_d, mem_read, mem_write;
        logic reg_write, reg_dst, mem_to_reg, halted, fault;
    } ctl_t;

    typedef struct {
        logic [3:0] op;
        bit         mr;
        bit         z;
        ctl_t       exp;
        ctl_t       mask;
        string      tag;
    } item_t;

    item_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic ctl_t obs();
        ctl_t o;
        o.alu_op = bus.alu_op; o.src_a = bus.alu_src_a; o.src_b = bus.alu_src_b;
        o.pc_src = bus.pc_src; o.pc_write = bus.pc_write; o.pc_write_cond = bus.pc_write_cond;
        o.ir_load = bus.ir_load; o.i_or_d = bus.i_or_d; o.mem_read = bus.mem_read;
        o.mem_write = bus.mem_write; o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg; o.halted = bus.halted; o.fault = bus.fault;
        return o;
    endfunction

    // Expected control word for each state, straight from the control table.
    function automatic ctl_t exp_ctl(int st, bit mr, bit rdst);
        ctl_t e;
        e = '0;
        case (st)
            T_FETCH:  begin e.mem_read = 1; e.src_b = 2'b01; e.ir_load = mr; e.pc_write = mr; end
            T_DECODE: e.src_b = 2'b11;
            T_ADDR:   begin e.src_a = 1; e.src_b = 2'b10; end
            T_MEM_RD: begin e.mem_read = 1; e.i_or_d = 1; end
            T_MEM_WR: begin e.mem_write = 1; e.i_or_d = 1; end
            T_WB_MEM: begin e.reg_write = 1; e.mem_to_reg = 1; end
            T_EXEC_R: begin e.alu_op = 2'b10; e.src_a = 1; end
            T_EXEC_S, T_EXEC_I: begin e.alu_op = 2'b11; e.src_b = 2'b10; end
            T_WB_ALU: begin e.reg_write = 1; e.reg_dst = rdst; end
            T_BRANCH: begin e.alu_op = 2'b01; e.src_a = 1; e.pc_write_cond = 1; e.pc_src = 2'b01; end
            T_JUMP:   begin e.pc_write = 1; e.pc_src = 2'b10; end
            T_HALT:   e.halted = 1;
            T_FAULT:  e.fault = 1;
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic push(int st, logic [3:0] op, bit mr, bit z, bit rdst, string tag);
        item_t it;
        it.op = op; it.mr = mr; it.z = z; it.tag = tag;
        it.exp = exp_ctl(st, mr, rdst);
        it.mask = '1;
        if (st == T_EXEC_S || st == T_EXEC_I) it.mask.src_a = 1'b0;  // operand A not fixed here
        sb.push_back(it);
    endtask

    task automatic do_reset(logic [3:0] op);
        @(negedge clk);
        rst = 1'b1; bus.opcode = op; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        item_t it;
        bus.opcode = 4'b0000; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        #2;
        n_checks++;
        if (obs() !== ctl_t'(0)) begin
            n_fail++; $display("FAIL reset_hold: got %h want 0", obs());
        end
        @(negedge clk); rst = 1'b0;
        push(T_FETCH, 4'b0000, 1, 0, 0, "rst_fetch");
        push(T_DECODE, 4'b0000, 0, 0, 0, "rst_lw_decode");
        push(T_ADDR, 4'b0000, 0, 0, 0, "rst_lw_addr");
        push(T_MEM_RD, 4'b0000, 0, 0, 0, "rst_lw_memrd");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
        #1; n_checks++;
        if (bus.i_or_d !== 1'b1 || bus.mem_read !== 1'b1) begin
            n_fail++; $display("FAIL rst_still_memrd: i_or_d=%b mem_read=%b want 1 1", bus.i_or_d, bus.mem_read);
        end
        rst = 1'b1; #1; n_checks++;
        if (obs() !== ctl_t'(0)) begin
            n_fail++; $display("FAIL rst_async_drop: got %h want 0", obs());
        end
        #1; rst = 1'b0; #1; n_checks++;
        if (obs() !== exp_ctl(T_FETCH, 0, 0)) begin
            n_fail++; $display("FAIL rst_back_fetch: got %h want %h", obs(), exp_ctl(T_FETCH, 0, 0));
        end
        @(negedge clk); #1; n_checks++;
        if (obs() !== exp_ctl(T_FETCH, 0, 0)) begin
            n_fail++; $display("FAIL rst_fetch_after_edge: got %h want %h", obs(), exp_ctl(T_FETCH, 0, 0));
        end
    endtask

    task automatic test_rtype();
        item_t it;
        do_reset(4'b0001);
        push(T_FETCH, 4'b0001, 1, 0, 0, "r_fetch");
        push(T_DECODE, 4'b0001, 1, 0, 0, "r_decode");
        push(T_EXEC_R, 4'b0001, 1, 0, 0, "r_exec");
        push(T_WB_ALU, 4'b0001, 1, 0, 1, "r_wb");
        push(T_FETCH, 4'b0001, 0, 0, 0, "r_next_fetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        item_t it;
        do_reset(4'b0000);
        push(T_FETCH, 4'b0000, 1, 0, 0, "lw_fetch");
        push(T_DECODE, 4'b0000, 0, 0, 0, "lw_decode");
        push(T_ADDR, 4'b0000, 0, 0, 0, "lw_addr");
        for (int i = 0; i < 3; i++) push(T_MEM_RD, 4'b0000, 0, 0, 0, "lw_memrd_wait");
        push(T_MEM_RD, 4'b0000, 1, 0, 0, "lw_memrd_done");
        push(T_WB_MEM, 4'b0000, 1, 0, 0, "lw_wb");
        push(T_FETCH, 4'b0000, 0, 0, 0, "lw_next_fetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        item_t it;
        do_reset(4'b0100);
        for (int k = 0; k < 2; k++) begin
            push(T_FETCH, 4'b0100, 1, 0, 0, "beq_fetch");
            push(T_DECODE, 4'b0100, 1, 0, 0, "beq_decode");
            push(T_BRANCH, 4'b0100, 1, (k == 0), 0, "beq_branch");
        end
        push(T_FETCH, 4'b0100, 0, 0, 0, "beq_next_fetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        item_t it;
        do_reset(4'b0001);
        push(T_FETCH, 4'b0001, 1, 0, 0, "b2b_r_fetch");
        push(T_DECODE, 4'b0001, 0, 0, 0, "b2b_r_decode");
        push(T_EXEC_R, 4'b0001, 0, 0, 0, "b2b_r_exec");
        push(T_WB_ALU, 4'b0001, 0, 0, 1, "b2b_r_wb");
        push(T_FETCH, 4'b0010, 1, 0, 0, "b2b_s_fetch");
        push(T_DECODE, 4'b0010, 1, 0, 0, "b2b_s_decode");
        push(T_EXEC_S, 4'b0010, 1, 0, 0, "b2b_s_exec");
        push(T_WB_ALU, 4'b0010, 1, 0, 0, "b2b_s_wb");
        push(T_FETCH, 4'b0101, 1, 0, 0, "b2b_i_fetch");
        push(T_DECODE, 4'b0101, 1, 0, 0, "b2b_i_decode");
        push(T_EXEC_I, 4'b0101, 1, 0, 0, "b2b_i_exec");
        push(T_WB_ALU, 4'b0101, 1, 0, 0, "b2b_i_wb");
        push(T_FETCH, 4'b0110, 1, 0, 0, "b2b_j_fetch");
        push(T_DECODE, 4'b0110, 1, 0, 0, "b2b_j_decode");
        push(T_JUMP, 4'b0110, 0, 0, 0, "b2b_j_jump");
        push(T_FETCH, 4'b0011, 1, 0, 0, "b2b_sw_fetch");
        push(T_DECODE, 4'b0011, 1, 0, 0, "b2b_sw_decode");
        push(T_ADDR, 4'b0011, 1, 0, 0, "b2b_sw_addr");
        push(T_MEM_WR, 4'b0011, 0, 0, 0, "b2b_sw_wait");
        push(T_MEM_WR, 4'b0011, 1, 0, 0, "b2b_sw_done");
        push(T_FETCH, 4'b0011, 0, 0, 0, "b2b_next_fetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        item_t it;
        do_reset(4'b0001);
        for (int i = 0; i < 15; i++) push(T_FETCH, 4'b0001, 0, 0, 0, "to_fetch_wait");
        push(T_FETCH, 4'b0001, 0, 0, 0, "to_fetch_last");
        sb[$].exp.mem_read = 1'b0; sb[$].mask.mem_read = 1'b0;  // read strobe may be withdrawn here
        for (int i = 0; i < 4; i++) push(T_FAULT, 4'b0001, (i % 2 == 0), 0, 0, "to_fault");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        item_t it;
        do_reset(4'b1001);
        push(T_FETCH, 4'b1001, 1, 0, 0, "ill_fetch");
        push(T_DECODE, 4'b1001, 1, 0, 0, "ill_decode");
        for (int i = 0; i < 3; i++) push(T_FAULT, 4'b0001, 1, 0, 0, "ill_fault");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        item_t it;
        do_reset(4'b1111);
        push(T_FETCH, 4'b1111, 1, 0, 0, "halt_fetch");
        push(T_DECODE, 4'b1111, 1, 0, 0, "halt_decode");
        for (int i = 0; i < 100; i++)
            push(T_HALT, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, "halt_hold");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf();
        item_t it;
        do_reset(4'b0101);
        #1; n_checks++;
        if (bus.retired !== 16'd0) begin
            n_fail++; $display("FAIL perf_reset: got %0d want 0", bus.retired);
        end
        for (int k = 0; k < 3; k++) begin
            push(T_FETCH, 4'b0101, 1, 0, 0, "perf_fetch");
            push(T_DECODE, 4'b0101, 1, 0, 0, "perf_decode");
            push(T_EXEC_I, 4'b0101, 1, 0, 0, "perf_exec");
            push(T_WB_ALU, 4'b0101, 1, 0, 0, "perf_wb");
        end
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.opcode = it.op; bus.mem_ready = it.mr; bus.zero = it.z;
            #1; n_checks++;
            if ((obs() & it.mask) !== (it.exp & it.mask)) begin
                n_fail++; $display("FAIL %s: got %h want %h", it.tag, obs() & it.mask, it.exp & it.mask);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1; n_checks++;
        if (bus.retired !== 16'd3) begin
            n_fail++; $display("FAIL perf_count: got %0d want 3", bus.retired);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_halt();
`ifdef CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
